i2c_register_target: RTL and testbench

I2C_REGISTER_TARGET -- requirements
Module: i2c_register_target

---
 rtl/i2c_target_pkg.sv | 32 +++
 rtl/i2c_register_target_if.sv | 9 +
 rtl/i2c_target_line_conditioner.sv | 67 ++++++
 rtl/i2c_register_target.sv | 264 ++++++++++++++++++++++++++
 tb/tb_i2c_register_target.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target: FSM state encoding,
// ACK-slot phases, START/STOP SDA transition patterns and a majority helper.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEVICE_ADDRESS,
    S_ADDRESS_ACK,
    S_REGISTER_ADDRESS,
    S_REGISTER_ACK,
    S_WRITE_DATA,
    S_WRITE_ACK,
    S_READ_DATA,
    S_READ_ACK
  } state_t;

  // ACK slot walks fall -> (rise) -> fall; the middle phase matters only for reads.
  typedef enum logic [1:0] {
    ACK_WAIT_FALL,
    ACK_DRIVEN,
    ACK_SAMPLED
  } ack_phase_t;

  // {previous SDA, current SDA} while SCL is high.
  localparam logic [1:0] START_SDA_TRANSITION = 2'b10;
  localparam logic [1:0] STOP_SDA_TRANSITION  = 2'b01;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_register_target_if.sv
// Pad-side I2C signals of the register target (open-drain SDA as a pull-low enable).
interface i2c_register_target_if;
  logic serial_clock;
  logic serial_data_in;
  logic serial_data_pull_low;

  modport master (output serial_clock, output serial_data_in, input serial_data_pull_low);
  modport slave  (input serial_clock, input serial_data_in, output serial_data_pull_low);
endinterface

// File: rtl/i2c_target_line_conditioner.sv
// SCL/SDA synchroniser, optional 3-sample majority filter, SCL edge and START/STOP detect.
// Optional filter: define I2C_TARGET_GLITCH_FILTER_EN (adds 2 cycles latency).
module i2c_target_line_conditioner
  import i2c_target_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic serial_clock,
  input  logic serial_data,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_condition,
  output logic stop_condition
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_clean, sda_clean;
  logic       scl_prev, sda_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], serial_clock};
      sda_sync <= {sda_sync[0], serial_data};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_taps, sda_taps;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_taps <= '1;
      sda_taps <= '1;
    end else begin
      scl_taps <= {scl_taps[1:0], scl_sync[1]};
      sda_taps <= {sda_taps[1:0], sda_sync[1]};
    end
  end

  assign scl_clean = majority3(scl_taps);
  assign sda_clean = majority3(sda_taps);
`else
  assign scl_clean = scl_sync[1];
  assign sda_clean = sda_sync[1];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_clean;
      sda_prev <= sda_clean;
    end
  end

  assign sda_level       = sda_clean;
  assign scl_rise        = scl_clean & ~scl_prev;
  assign scl_fall        = ~scl_clean & scl_prev;
  assign start_condition = scl_clean & scl_prev & ({sda_prev, sda_clean} == START_SDA_TRANSITION);
  assign stop_condition  = scl_clean & scl_prev & ({sda_prev, sda_clean} == STOP_SDA_TRANSITION);

endmodule

// File: rtl/i2c_register_target.sv
// I2C target exposing a bank of register words to the bus and to a local host port.
// Build option: I2C_TARGET_GLITCH_FILTER_EN enables line glitch filtering.
module i2c_register_target
  import i2c_target_pkg::*;
#(
  parameter int                 NUMBER_OF_DATA_BYTES     = 1,
  parameter int                 NUMBER_OF_REGISTER_BYTES = 1,
  parameter int                 ADDRESS_WIDTH            = 7,
  parameter logic [ADDRESS_WIDTH-1:0] DEVICE_ADDRESS     = 7'h11,
  parameter int                 REGISTER_DEPTH           = 16,
  localparam int                DW = NUMBER_OF_DATA_BYTES * 8,
  localparam int                IW = $clog2(REGISTER_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  i2c_register_target_if.slave  bus,
  input  logic [IW-1:0]         host_register_address,
  input  logic                  host_write_enable,
  input  logic [DW-1:0]         host_write_data,
  output logic [DW-1:0]         host_read_data,
  output logic                  bus_write_strobe,
  output logic [IW-1:0]         bus_write_index,
  output logic                  busy
);

  localparam int PW = NUMBER_OF_REGISTER_BYTES * 8;

  logic sda_level, scl_rise, scl_fall, start_condition, stop_condition;

  i2c_target_line_conditioner u_line (
    .clock           (clock),
    .reset           (reset),
    .serial_clock    (bus.serial_clock),
    .serial_data     (bus.serial_data_in),
    .sda_level       (sda_level),
    .scl_rise        (scl_rise),
    .scl_fall        (scl_fall),
    .start_condition (start_condition),
    .stop_condition  (stop_condition)
  );

  state_t     state, state_n;
  ack_phase_t ack_phase, ack_phase_n;
  logic [2:0]    bit_count, bit_count_n;
  logic [1:0]    byte_count, byte_count_n;
  logic [7:0]    shift_in, shift_in_n, byte_in;
  logic [PW-1:0] pointer, pointer_n, addr_acc, addr_acc_n, addr_assembled, pointer_next;
  logic [DW-1:0] wr_word, wr_word_n, tx_word, tx_word_n, pointer_word;
  logic          rw, rw_n, pull_low, pull_low_n, busy_n, commit, commit_valid, pointer_in_range;
  logic [DW-1:0] registers [REGISTER_DEPTH];

  assign byte_in          = {shift_in[6:0], sda_level};
  assign addr_assembled   = (addr_acc << 8) | PW'(byte_in);
  assign pointer_in_range = 32'(pointer) < 32'(REGISTER_DEPTH);
  assign pointer_word     = pointer_in_range ? registers[pointer[IW-1:0]] : '0;
  assign pointer_next     = (32'(pointer) == 32'(REGISTER_DEPTH - 1)) ? '0 : pointer + PW'(1);
  assign commit_valid     = commit & pointer_in_range;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ack_phase  <= ACK_WAIT_FALL;
      bit_count  <= '0;
      byte_count <= '0;
      shift_in   <= '0;
      pointer    <= '0;
      addr_acc   <= '0;
      wr_word    <= '0;
      tx_word    <= '0;
      rw         <= 1'b0;
      pull_low   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ack_phase  <= ack_phase_n;
      bit_count  <= bit_count_n;
      byte_count <= byte_count_n;
      shift_in   <= shift_in_n;
      pointer    <= pointer_n;
      addr_acc   <= addr_acc_n;
      wr_word    <= wr_word_n;
      tx_word    <= tx_word_n;
      rw         <= rw_n;
      pull_low   <= pull_low_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    ack_phase_n  = ack_phase;
    bit_count_n  = bit_count;
    byte_count_n = byte_count;
    shift_in_n   = shift_in;
    pointer_n    = pointer;
    addr_acc_n   = addr_acc;
    wr_word_n    = wr_word;
    tx_word_n    = tx_word;
    rw_n         = rw;
    pull_low_n   = pull_low;
    busy_n       = busy;
    commit       = 1'b0;
    if (stop_condition) begin
      state_n    = S_IDLE;
      pull_low_n = 1'b0;
      busy_n     = 1'b0;
    end else if (start_condition) begin
      state_n      = S_DEVICE_ADDRESS;
      bit_count_n  = '0;
      byte_count_n = '0;
      ack_phase_n  = ACK_WAIT_FALL;
      pull_low_n   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_DEVICE_ADDRESS: if (scl_rise) begin
          shift_in_n  = byte_in;
          bit_count_n = bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            if (byte_in[7 -: ADDRESS_WIDTH] == DEVICE_ADDRESS) begin
              state_n     = S_ADDRESS_ACK;
              ack_phase_n = ACK_WAIT_FALL;
              rw_n        = sda_level;
              busy_n      = 1'b1;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_ADDRESS_ACK: if (scl_fall) begin
          if (ack_phase == ACK_WAIT_FALL) begin
            pull_low_n  = 1'b1;
            ack_phase_n = ACK_DRIVEN;
          end else begin
            ack_phase_n  = ACK_WAIT_FALL;
            bit_count_n  = '0;
            byte_count_n = '0;
            if (rw) begin
              state_n    = S_READ_DATA;
              tx_word_n  = pointer_word;
              pull_low_n = ~pointer_word[DW-1];
            end else begin
              state_n    = S_REGISTER_ADDRESS;
              pull_low_n = 1'b0;
            end
          end
        end
        S_REGISTER_ADDRESS: if (scl_rise) begin
          shift_in_n  = byte_in;
          bit_count_n = bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            addr_acc_n  = addr_assembled;
            state_n     = S_REGISTER_ACK;
            ack_phase_n = ACK_WAIT_FALL;
            if (byte_count == 2'(NUMBER_OF_REGISTER_BYTES - 1)) pointer_n = addr_assembled;
          end
        end
        S_REGISTER_ACK: if (scl_fall) begin
          if (ack_phase == ACK_WAIT_FALL) begin
            pull_low_n  = 1'b1;
            ack_phase_n = ACK_DRIVEN;
          end else begin
            pull_low_n  = 1'b0;
            ack_phase_n = ACK_WAIT_FALL;
            bit_count_n = '0;
            if (byte_count == 2'(NUMBER_OF_REGISTER_BYTES - 1)) begin
              state_n      = S_WRITE_DATA;
              byte_count_n = '0;
            end else begin
              state_n      = S_REGISTER_ADDRESS;
              byte_count_n = byte_count + 2'd1;
            end
          end
        end
        S_WRITE_DATA: if (scl_rise) begin
          shift_in_n  = byte_in;
          bit_count_n = bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            wr_word_n   = (wr_word << 8) | DW'(byte_in);
            state_n     = S_WRITE_ACK;
            ack_phase_n = ACK_WAIT_FALL;
          end
        end
        S_WRITE_ACK: if (scl_fall) begin
          if (ack_phase == ACK_WAIT_FALL) begin
            pull_low_n  = 1'b1;
            ack_phase_n = ACK_DRIVEN;
          end else begin
            pull_low_n  = 1'b0;
            ack_phase_n = ACK_WAIT_FALL;
            bit_count_n = '0;
            state_n     = S_WRITE_DATA;
            if (byte_count == 2'(NUMBER_OF_DATA_BYTES - 1)) begin
              commit       = 1'b1;
              pointer_n    = pointer_next;
              byte_count_n = '0;
            end else begin
              byte_count_n = byte_count + 2'd1;
            end
          end
        end
        S_READ_DATA: begin
          if (scl_rise) begin
            tx_word_n   = tx_word << 1;
            bit_count_n = bit_count + 3'd1;
            if (bit_count == 3'd7) begin
              state_n     = S_READ_ACK;
              ack_phase_n = ACK_WAIT_FALL;
            end
          end else if (scl_fall) begin
            pull_low_n = ~tx_word[DW-1];
          end
        end
        S_READ_ACK: begin
          // Pointer advances once the last byte of a word has been clocked out,
          // so a continuing read loads the following word on the next fall.
          if (scl_fall && ack_phase == ACK_WAIT_FALL) begin
            pull_low_n  = 1'b0;
            ack_phase_n = ACK_DRIVEN;
          end else if (scl_rise && ack_phase == ACK_DRIVEN) begin
            if (byte_count == 2'(NUMBER_OF_DATA_BYTES - 1)) pointer_n = pointer_next;
            if (sda_level) state_n = S_IDLE;
            else ack_phase_n = ACK_SAMPLED;
          end else if (scl_fall && ack_phase == ACK_SAMPLED) begin
            state_n     = S_READ_DATA;
            ack_phase_n = ACK_WAIT_FALL;
            bit_count_n = '0;
            if (byte_count == 2'(NUMBER_OF_DATA_BYTES - 1)) begin
              byte_count_n = '0;
              tx_word_n    = pointer_word;
              pull_low_n   = ~pointer_word[DW-1];
            end else begin
              byte_count_n = byte_count + 2'd1;
              pull_low_n   = ~tx_word[DW-1];
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Bus commit is written last so it wins over a same-index host write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < REGISTER_DEPTH; i++) registers[i] <= '0;
      bus_write_strobe <= 1'b0;
      bus_write_index  <= '0;
    end else begin
      if (host_write_enable && (32'(host_register_address) < 32'(REGISTER_DEPTH)))
        registers[host_register_address] <= host_write_data;
      if (commit_valid) begin
        registers[pointer[IW-1:0]] <= wr_word;
        bus_write_index            <= pointer[IW-1:0];
      end
      bus_write_strobe <= commit_valid;
    end
  end

  assign host_read_data = (32'(host_register_address) < 32'(REGISTER_DEPTH))
                          ? registers[host_register_address] : '0;
  assign bus.serial_data_pull_low = pull_low;

endmodule

// File: tb/tb_i2c_register_target.sv
// Self-checking bench for i2c_register_target: table of write transactions plus
// hand-written read, abort and glitch sequences; bus runs near 400 kHz at 50 MHz.
module tb_i2c_register_target;

  localparam int Q  = 30;
  localparam int NV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_register_address = '0;
  logic       host_write_enable = 1'b0;
  logic [7:0] host_write_data = '0;
  logic [7:0] host_read_data;
  logic       bus_write_strobe;
  logic [3:0] bus_write_index;
  logic       busy;

  always #10 clock = ~clock;

  i2c_register_target_if bus ();
  assign bus.serial_clock   = scl_m;
  assign bus.serial_data_in = sda_m & ~bus.serial_data_pull_low;

  i2c_register_target #(
    .NUMBER_OF_DATA_BYTES     (1),
    .NUMBER_OF_REGISTER_BYTES (1),
    .ADDRESS_WIDTH            (7),
    .DEVICE_ADDRESS           (7'h11),
    .REGISTER_DEPTH           (16)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .bus                   (bus),
    .host_register_address (host_register_address),
    .host_write_enable     (host_write_enable),
    .host_write_data       (host_write_data),
    .host_read_data        (host_read_data),
    .bus_write_strobe      (bus_write_strobe),
    .bus_write_index       (bus_write_index),
    .busy                  (busy)
  );

  typedef struct {
    logic [6:0]      dev;
    logic [7:0]      reg_addr;
    int              n_data;
    logic [1:0][7:0] data;
    logic            expect_ack;
  } wr_vec_t;

  int         checks = 0;
  int         passes = 0;
  int         strobe_count = 0;
  int         pull_cycles = 0;
  int         exp_index_q [$];
  logic [7:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clock) if (bus.serial_data_pull_low === 1'b1) pull_cycles++;

  // Scoreboard: each strobe must match the next index queued when its data byte was sent.
  always @(negedge clock) begin
    if (!reset && bus_write_strobe === 1'b1) begin
      strobe_count++;
      check("strobe_expected", 32'(exp_index_q.size() != 0), 32'd1);
      if (exp_index_q.size() != 0) check("strobe_index", 32'(bus_write_index), 32'(exp_index_q.pop_front()));
    end
  end

  initial begin
    repeat (150000) @(posedge clock);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic wait_q();
    repeat (Q) @(posedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    wait_q(); sda_m = b;
    wait_q(); scl_m = 1'b1;
    wait_q();
    if (glitch) begin
      @(negedge clock) scl_m = 1'b0;
      @(negedge clock) scl_m = 1'b1;
    end
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b1; wait_q();
    @(negedge clock) b = bus.serial_data_in;
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_pos, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_pos);
    recv_bit(ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack, 1'b0);
  endtask

  task automatic peek_reg(input int r, input string name);
    @(negedge clock) host_register_address = 4'(r);
    @(negedge clock) check(name, 32'(host_read_data), 32'(model[r]));
  endtask

  initial begin
    wr_vec_t    vecs [NV];
    logic       ack;
    logic [7:0] d;
    int         snap, idx;

    vecs[0] = '{dev: 7'h11, reg_addr: 8'h03, n_data: 1, data: {8'h00, 8'hA5}, expect_ack: 1'b1};
    vecs[1] = '{dev: 7'h11, reg_addr: 8'h0F, n_data: 2, data: {8'h02, 8'h01}, expect_ack: 1'b1};
    vecs[2] = '{dev: 7'h41, reg_addr: 8'h07, n_data: 1, data: {8'h00, 8'h5A}, expect_ack: 1'b0};
    vecs[3] = '{dev: 7'h11, reg_addr: 8'h09, n_data: 1, data: {8'h00, 8'hC3}, expect_ack: 1'b1};
    for (int r = 0; r < 16; r++) model[r] = '0;

    repeat (5) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("reset_pull_low", 32'(bus.serial_data_pull_low), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_strobe", 32'(bus_write_strobe), 32'd0);
    check("reset_index", 32'(bus_write_index), 32'd0);
    check("reset_reg0", 32'(host_read_data), 32'd0);

    for (int v = 0; v < NV; v++) begin
      snap = pull_cycles;
      i2c_start();
      write_byte({vecs[v].dev, 1'b0}, -1, ack);
      check("addr_ack", 32'(ack), vecs[v].expect_ack ? 32'd0 : 32'd1);
      if (vecs[v].expect_ack) begin
        check("busy_after_match", 32'(busy), 32'd1);
        write_byte(vecs[v].reg_addr, -1, ack);
        check("reg_ack", 32'(ack), 32'd0);
        for (int k = 0; k < vecs[v].n_data; k++) begin
          idx = (int'(vecs[v].reg_addr) + k) % 16;
          exp_index_q.push_back(idx);
          model[idx] = vecs[v].data[k];
          write_byte(vecs[v].data[k], -1, ack);
          check("data_ack", 32'(ack), 32'd0);
        end
      end else begin
        check("busy_no_match", 32'(busy), 32'd0);
      end
      i2c_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      if (!vecs[v].expect_ack) check("no_sda_drive", 32'(pull_cycles - snap), 32'd0);
    end
    for (int r = 0; r < 16; r++) peek_reg(r, "reg_after_writes");

    // Host write, then write-pointer + repeated START + single-byte read with NACK.
    @(negedge clock) begin host_register_address = 4'd5; host_write_data = 8'h3C; host_write_enable = 1'b1; end
    @(negedge clock) host_write_enable = 1'b0;
    model[5] = 8'h3C;
    i2c_start(); write_byte(8'h22, -1, ack); write_byte(8'h05, -1, ack);
    i2c_start(); write_byte(8'h23, -1, ack);
    check("read_addr_ack", 32'(ack), 32'd0);
    read_byte(1'b1, d);
    check("read_reg5", 32'(d), 32'(model[5]));
    i2c_stop();
    check("read_busy_after_stop", 32'(busy), 32'd0);
    check("read_released", 32'(bus.serial_data_pull_low), 32'd0);

    // Two-word read across the wrap point.
    i2c_start(); write_byte(8'h22, -1, ack); write_byte(8'h0F, -1, ack);
    i2c_start(); write_byte(8'h23, -1, ack);
    read_byte(1'b0, d); check("read_wrap_15", 32'(d), 32'(model[15]));
    read_byte(1'b1, d); check("read_wrap_0", 32'(d), 32'(model[0]));
    i2c_stop();

    // Out-of-range register reads as zero.
    i2c_start(); write_byte(8'h22, -1, ack); write_byte(8'h20, -1, ack);
    check("oor_reg_ack", 32'(ack), 32'd0);
    i2c_start(); write_byte(8'h23, -1, ack);
    read_byte(1'b1, d); check("read_out_of_range", 32'(d), 32'd0);
    i2c_stop();

    // STOP after four data bits discards the partial byte.
    snap = strobe_count;
    i2c_start(); write_byte(8'h22, -1, ack); write_byte(8'h02, -1, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    i2c_stop();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_strobe", 32'(strobe_count - snap), 32'd0);
    peek_reg(2, "abort_reg2");

    // One-cycle SCL low pulse during the MSB of data 0x96 to register 6.
    i2c_start(); write_byte(8'h22, -1, ack); write_byte(8'h06, -1, ack);
    exp_index_q.push_back(6);
    write_byte(8'h96, 7, ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    model[6] = 8'h96;
    check("glitch_data_ack", 32'(ack), 32'd0);
`else
    model[6] = 8'hCB;
    check("glitch_data_ack", 32'(ack), 32'd1);
`endif
    i2c_stop();
    peek_reg(6, "glitch_reg6");

    repeat (10) @(posedge clock);
    check("strobes_all_seen", 32'(exp_index_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
